fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding control_unit/datapath in the RV32I core. Holds the PC, runs a
//  req/ack handshake with instruction memory (variable latency), latches the fetched word and
//  presents it with op/funct3/funct7b5 pre-sliced for decode. On retire it advances the PC to
//  PC+4 or PC+immext, using pcsrc from control_unit. Misaligned targets and memory timeouts raise a sticky fault.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be word-aligned
//  TIMEOUT   15             max cycles in REQ without ack before fault (1..255)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  imem_req    out  1   fetch request; imem_addr valid while high
//  imem_addr   out  32  byte address of requested word (== pc)
//  imem_ack    in   1   memory has imem_rdata valid this cycle
//  imem_rdata  in   32  instruction word
//  instr_accept in  1   datapath executed the presented instr this cycle (retire)
//  pcsrc       in   1   from control_unit: take branch/jump target on retire
//  immext      in   32  sign-extended immediate for target calc
//  instr       out  32  latched instruction
//  instr_valid out  1   instr/pc valid for decode/execute
//  op          out  7   instr[6:0]
//  funct3      out  3   instr[14:12]
//  funct7b5    out  1   instr[30]
//  pc          out  32  address of instr
//  pcplus4     out  32  pc + 4 (jal link value)
//  fetch_fault out  1   sticky: timeout or misaligned target
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0,
//   fetch_fault=0, timeout counter=0, state=IDLE. Outstanding request abandoned; ack ignored.
//  FSM: IDLE -> REQ (unconditional, 1 cycle after reset release).
//   REQ: imem_req=1, imem_addr=pc held stable. On a clk edge with imem_ack=1: instr<=imem_rdata,
//    -> VALID. Ack in same cycle req first rises is legal (zero-wait memory). Otherwise counter++;
//    when counter reaches TIMEOUT with no ack -> FAULT.
//   VALID: instr_valid=1, imem_req=0. Holds until instr_accept=1; then
//    next = pcsrc ? pc+immext : pc+4 (32-bit wrap, carry dropped), counter=0.
//    next[1:0]!=0 -> FAULT (pc not updated); else pc<=next, -> REQ.
//   FAULT: fetch_fault=1, imem_req=0, instr_valid=0; exit only via reset.
//  Latency: ack edge -> instr_valid high next cycle; accept edge -> imem_req high next cycle.
//   Zero-wait memory and always-accept: one instruction per 2 cycles.
//  imem_ack outside REQ is ignored. instr_accept outside VALID is ignored.
//  pcsrc/immext are sampled only on the accepting edge.
//  op/funct3/funct7b5/pcplus4 are combinational slices of the instr/pc registers.
//  They stay stable while instr_valid=1.
// TESTING
//  1 release rst_n, ack same cycle with rdata=0x00500093 -> req addr 0x0; next cycle
//    instr_valid=1, op=7'b0010011, funct3=0, pc=0, pcplus4=4.
//  2 accept with pcsrc=0 at pc=0x0 -> next req addr 0x4; accept pcsrc=1 immext=0xFFFFFFF8
//    at pc=0x10 -> next req addr 0x08.
//  3 ack delayed 3 cycles -> imem_req held 4 cycles, addr constant; instr_valid stays 0 until after ack.
//  4 no ack for TIMEOUT=15 cycles -> fetch_fault=1, imem_req=0; later acks ignored.
//  5 accept with pcsrc=1 immext=0x6 at pc=0x0 -> fetch_fault=1, pc stays 0x0, no new req.
//  6 rst_n low mid-REQ, ack after release -> pc=RESET_PC, fresh req, stale ack not latched.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with instruction memory,
// and presents the latched word with its decode fields until the datapath retires it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        instr_accept,
    input  logic        pcsrc,
    input  logic [31:0] immext,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  cnt_inc;
    logic [31:0] target;

    // Carry out of the target adder is dropped, so branches wrap around the address space.
    assign target  = pcsrc ? (pc_reg + immext) : (pc_reg + 32'd4);
    assign cnt_inc = cnt_reg + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= NOP;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
                cnt_next   = 8'd0;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    cnt_next   = 8'd0;
                    state_next = VALID;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        state_next = FAULT;
                    end
                end
            end
            VALID: begin
                if (instr_accept) begin
                    cnt_next = 8'd0;
                    // A misaligned target leaves pc pointing at the instruction that caused it.
                    if (target[1:0] != 2'b00) begin
                        state_next = FAULT;
                    end else begin
                        pc_next    = target;
                        state_next = REQ;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_reg == REQ);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == VALID);
    assign fetch_fault = (state_reg == FAULT);
    assign instr       = instr_reg;
    assign pc          = pc_reg;
    assign pcplus4     = pc_reg + 32'd4;
    assign op          = instr_reg[6:0];
    assign funct3      = instr_reg[14:12];
    assign funct7b5    = instr_reg[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected (pc, instr) pairs is filled as
// memory acks are driven and drained when the fetch stage presents a valid instruction.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_accept;
    logic        pcsrc;
    logic [31:0] immext;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_accept (instr_accept),
        .pcsrc        (pcsrc),
        .immext       (immext),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .fetch_fault  (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        instr_accept = 1'b0;
        pcsrc        = 1'b0;
        tick();
        tick();
    endtask

    // Serve one fetch at exp_addr after 'delay' wait cycles and check the presented result.
    task automatic test_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int delay);
        int   n = 0;
        exp_t e;
        while (imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            $display("FAIL fetch_req: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, exp_addr);
        end else begin
            pass_cnt++;
        end
        imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            total_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
                $display("FAIL wait_hold: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                         imem_req, imem_addr, instr_valid, exp_addr);
            end else begin
                pass_cnt++;
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        e.pc       = exp_addr;
        e.instr    = rdata;
        exp_q.push_back(e);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        total_cnt++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || exp_q.size() == 0) begin
            $display("FAIL present_valid: valid=%b req=%b, required valid=1 req=0", instr_valid, imem_req);
        end else begin
            pass_cnt++;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (instr !== e.instr || pc !== e.pc || pcplus4 !== (e.pc + 32'd4)) begin
                $display("FAIL present_data: instr=%h pc=%h pcplus4=%h, required instr=%h pc=%h pcplus4=%h",
                         instr, pc, pcplus4, e.instr, e.pc, e.pc + 32'd4);
            end else begin
                pass_cnt++;
            end
            total_cnt++;
            if (op !== e.instr[6:0] || funct3 !== e.instr[14:12] || funct7b5 !== e.instr[30]) begin
                $display("FAIL decode_slices: op=%b f3=%b f7b5=%b, required op=%b f3=%b f7b5=%b",
                         op, funct3, funct7b5, e.instr[6:0], e.instr[14:12], e.instr[30]);
            end else begin
                pass_cnt++;
            end
        end
        $display("fetch addr=%h instr=%h delay=%0d", exp_addr, rdata, delay);
    endtask

    task automatic retire(input logic take, input logic [31:0] imm);
        instr_accept = 1'b1;
        pcsrc        = take;
        immext       = imm;
        tick();
        instr_accept = 1'b0;
        pcsrc        = ~take;
        immext       = $urandom;
        $display("retire pcsrc=%b immext=%h", take, imm);
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if (pc !== 32'h0 || instr !== 32'h0000_0013 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
            fetch_fault !== 1'b0 || op !== 7'b0010011) begin
            $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b fault=%b op=%b, required 0/00000013/0/0/0/0010011",
                     pc, instr, instr_valid, imem_req, fetch_fault, op);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_zero_wait();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (imem_req !== 1'b1) begin
            $display("FAIL first_req_latency: req=%b, required 1", imem_req);
        end else begin
            pass_cnt++;
        end
        test_fetch(32'h0, 32'h0050_0093, 0);
        total_cnt++;
        if (op !== 7'b0010011 || funct3 !== 3'd0 || pc !== 32'h0 || pcplus4 !== 32'h4) begin
            $display("FAIL addi_decode: op=%b f3=%0d pc=%h pcplus4=%h, required 0010011/0/0/4", op, funct3, pc, pcplus4);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_sequential_and_branch();
        retire(1'b0, 32'h0);
        test_fetch(32'h4, $urandom, 0);
        retire(1'b0, 32'h0);
        test_fetch(32'h8, $urandom, 1);
        retire(1'b0, 32'h0);
        test_fetch(32'hC, $urandom, 0);
        retire(1'b0, 32'h0);
        test_fetch(32'h10, $urandom, 0);
        retire(1'b1, 32'hFFFF_FFF8);
        test_fetch(32'h08, 32'h4020_8033, 3);
    endtask

    task automatic test_hold_valid();
        logic [31:0] held;
        held = instr;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = ~held;
            tick();
            total_cnt++;
            if (instr !== held || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h08) begin
                $display("FAIL hold_valid: instr=%h valid=%b req=%b pc=%h, required instr=%h valid=1 req=0 pc=00000008",
                         instr, instr_valid, imem_req, pc, held);
            end else begin
                pass_cnt++;
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        retire(1'b1, 32'hFFFF_FFF8);
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL accept_latency: req=%b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
        end else begin
            pass_cnt++;
        end
        test_fetch(32'h0, $urandom, 0);
        retire(1'b1, 32'hFFFF_FFFC);
        test_fetch(32'hFFFF_FFFC, $urandom, 0);
        total_cnt++;
        if (pcplus4 !== 32'h0) begin
            $display("FAIL pcplus4_wrap: pcplus4=%h, required 00000000", pcplus4);
        end else begin
            pass_cnt++;
        end
        retire(1'b0, 32'h0);
        test_fetch(32'h0, $urandom, 0);
    endtask

    task automatic test_misaligned();
        retire(1'b1, 32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (fetch_fault !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                $display("FAIL misaligned: fault=%b pc=%h req=%b valid=%b, required fault=1 pc=00000000 req=0 valid=0",
                         fetch_fault, pc, imem_req, instr_valid);
            end else begin
                pass_cnt++;
            end
            instr_accept = 1'b1;
            tick();
        end
        instr_accept = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int n = 0;
        apply_reset();
        rst_n = 1'b1;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        while (imem_req === 1'b1 && req_cycles < 40) begin
            total_cnt++;
            if (imem_addr !== 32'h0) begin
                $display("FAIL timeout_addr: addr=%h, required 00000000", imem_addr);
            end else begin
                pass_cnt++;
            end
            tick();
            req_cycles++;
        end
        $display("timeout req_cycles=%0d", req_cycles);
        total_cnt++;
        if (req_cycles != 15 || fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL timeout: req_cycles=%0d fault=%b req=%b, required 15/1/0", req_cycles, fetch_fault, imem_req);
        end else begin
            pass_cnt++;
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_ack = 1'b0;
        total_cnt++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
            $display("FAIL late_ack: fault=%b valid=%b instr=%h, required 1/0/00000013", fetch_fault, instr_valid, instr);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset_midreq();
        apply_reset();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD3;
        #2;
        total_cnt++;
        if (imem_req !== 1'b0 || fetch_fault !== 1'b0 || instr !== 32'h0000_0013 || pc !== 32'h0) begin
            $display("FAIL async_reset: req=%b fault=%b instr=%h pc=%h, required 0/0/00000013/00000000",
                     imem_req, fetch_fault, instr, pc);
        end else begin
            pass_cnt++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
            $display("FAIL stale_ack: req=%b addr=%h valid=%b instr=%h, required 1/00000000/0/00000013",
                     imem_req, imem_addr, instr_valid, instr);
        end else begin
            pass_cnt++;
        end
        test_fetch(32'h0, 32'h0010_0113, 2);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        instr_accept = 1'b0;
        pcsrc        = 1'b0;
        immext       = 32'h0;
        test_reset();
        test_zero_wait();
        test_sequential_and_branch();
        test_hold_valid();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_midreq();
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end else begin
            pass_cnt++;
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
